// File: rtl/udp_pkg.sv
// Shared definitions for the UDP transmit scheduler: FSM encoding,
// default payload limit and a small one-hot helper.
package udp_pkg;

  typedef enum logic [3:0] {
    ARP_REQ,
    ARP_SEND,
    ARP_WAIT,
    IDLE,
    REQ,
    STREAM,
    SEND_WAIT,
    GAP,
    CHECK
  } state_e;

  localparam logic [15:0] MAX_LEN_DEFAULT = 16'd1472;

  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin picker: the channel granted last time has the
// lower priority. Purely combinational; the owner register lives in the top.
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic       vld_o,
  output logic       idx_o
);

  always_comb begin
    vld_o = |req_i;
    idx_o = 1'b0;
    if (last_i) idx_o = req_i[0] ? 1'b0 : 1'b1;
    else        idx_o = req_i[1] ? 1'b1 : 1'b0;
  end

endmodule

// File: rtl/udp_tx_scheduler.sv
// Shares one UDP stack transmit port between two payload sources: resolves the
// destination MAC via ARP, then grants frames round-robin with an inter-frame gap.
module udp_tx_scheduler
  import udp_pkg::*;
#(
  parameter logic [31:0] ARP_TIMEOUT = 32'd125_000_000,
  parameter logic [15:0] IFG_CYCLES  = 16'd12,
  parameter logic [15:0] MAX_LEN     = MAX_LEN_DEFAULT
) (
  input  logic        rgmii_clk,
  input  logic        rstn,
  input  logic [1:0]  req,
  input  logic [15:0] len0,
  input  logic [15:0] len1,
  input  logic [1:0]  din_valid,
  input  logic [7:0]  din0,
  input  logic [7:0]  din1,
  output logic [1:0]  grant,
  output logic [1:0]  data_req,
  output logic [1:0]  done,
  output logic        err,
  output logic        link_ready,
  output logic        app_data_request,
  output logic [15:0] app_data_length,
  output logic        app_data_in_valid,
  output logic [7:0]  app_data_in,
  input  logic        udp_send_ack,
  input  logic        arp_found,
  input  logic        mac_not_exist,
  input  logic        mac_send_end,
  output logic        arp_req
);

  state_e      state_q, state_d;
  logic [31:0] tmo_q, tmo_d;
  logic [15:0] bcnt_q, bcnt_d;
  logic [15:0] gap_q, gap_d;
  logic        last_q, last_d;
  logic        gidx_q, gidx_d;
  logic [15:0] len_q, len_d;
  logic [1:0]  grant_q, grant_d;
  logic [1:0]  data_req_q, data_req_d;
  logic [1:0]  done_q, done_d;
  logic        err_q, err_d;
  logic        link_q, link_d;
  logic        app_req_q, app_req_d;
  logic [15:0] app_len_q, app_len_d;
  logic        app_vld_q, app_vld_d;
  logic [7:0]  app_din_q, app_din_d;
  logic        arp_req_q, arp_req_d;

  logic        arb_vld, arb_idx;
  logic [15:0] sel_len;
  logic [7:0]  sel_din;
  logic [15:0] bcnt_inc;
  logic        tmo_hit, gap_hit;

  function automatic logic len_ok(input logic [15:0] l);
    return (l != 16'd0) && (l <= MAX_LEN);
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // The channel whose done is on the wire this cycle still holds req; mask it
  // so it is not re-granted before it can drop the request.
  rr_arb2 u_arb (
    .req_i  (req & ~done_q),
    .last_i (last_q),
    .vld_o  (arb_vld),
    .idx_o  (arb_idx)
  );

  assign sel_len  = arb_idx ? len1 : len0;
  assign sel_din  = gidx_q ? din1 : din0;
  assign bcnt_inc = sat_inc16(bcnt_q);
  assign tmo_hit  = (ARP_TIMEOUT == 32'd0) || (tmo_q >= ARP_TIMEOUT - 32'd1);
  assign gap_hit  = (IFG_CYCLES == 16'd0) || (gap_q >= IFG_CYCLES - 16'd1);

  always_comb begin
    state_d    = state_q;
    tmo_d      = sat_inc32(tmo_q);
    bcnt_d     = bcnt_q;
    gap_d      = gap_q;
    last_d     = last_q;
    gidx_d     = gidx_q;
    len_d      = len_q;
    grant_d    = grant_q;
    data_req_d = data_req_q;
    done_d     = 2'b00;
    err_d      = 1'b0;
    link_d     = link_q;
    app_req_d  = app_req_q;
    app_len_d  = app_len_q;
    app_vld_d  = 1'b0;
    app_din_d  = app_din_q;
    arp_req_d  = 1'b0;

    case (state_q)
      ARP_REQ: begin
        arp_req_d = 1'b1;
        link_d    = 1'b0;
        state_d   = ARP_SEND;
      end
      ARP_SEND: if (mac_send_end) state_d = ARP_WAIT;
      ARP_WAIT: begin
        if (arp_found) begin
          link_d  = 1'b1;
          state_d = IDLE;
        end else if (tmo_hit) begin
          state_d = ARP_REQ;
        end
      end
      IDLE: begin
        if (arb_vld) begin
          gidx_d  = arb_idx;
          last_d  = arb_idx;
          len_d   = sel_len;
          grant_d = onehot2(arb_idx);
          if (len_ok(sel_len)) begin
            app_req_d = 1'b1;
            app_len_d = sel_len;
          end
          state_d = REQ;
        end
      end
      REQ: begin
        if (!len_ok(len_q)) begin
          done_d  = grant_q;
          err_d   = 1'b1;
          grant_d = 2'b00;
          state_d = IDLE;
        end else if (udp_send_ack) begin
          app_req_d  = 1'b0;
          app_len_d  = 16'd0;
          data_req_d = grant_q;
          bcnt_d     = 16'd0;
          state_d    = STREAM;
        end else if (tmo_hit) begin
          app_req_d = 1'b0;
          app_len_d = 16'd0;
          done_d    = grant_q;
          err_d     = 1'b1;
          grant_d   = 2'b00;
          state_d   = CHECK;
        end
      end
      STREAM: begin
        if (din_valid[gidx_q]) begin
          app_vld_d = 1'b1;
          app_din_d = sel_din;
          bcnt_d    = bcnt_inc;
          if (bcnt_inc >= len_q) begin
            data_req_d = 2'b00;
            state_d    = SEND_WAIT;
          end
        end
      end
      SEND_WAIT: begin
        if (mac_send_end) begin
          done_d  = grant_q;
          grant_d = 2'b00;
          state_d = (IFG_CYCLES == 16'd0) ? CHECK : GAP;
        end
      end
      GAP: begin
        gap_d = sat_inc16(gap_q);
        if (gap_hit) state_d = CHECK;
      end
      CHECK: begin
        if (mac_not_exist) begin
          link_d  = 1'b0;
          state_d = ARP_REQ;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = ARP_REQ;
    endcase

    // Both wait counters measure time spent in the current state only.
    if (state_d != state_q) begin
      tmo_d = 32'd0;
      gap_d = 16'd0;
    end
  end

  always_ff @(posedge rgmii_clk) begin
    if (!rstn) begin
      state_q    <= ARP_REQ;
      tmo_q      <= 32'd0;
      bcnt_q     <= 16'd0;
      gap_q      <= 16'd0;
      last_q     <= 1'b1;
      gidx_q     <= 1'b0;
      len_q      <= 16'd0;
      grant_q    <= 2'b00;
      data_req_q <= 2'b00;
      done_q     <= 2'b00;
      err_q      <= 1'b0;
      link_q     <= 1'b0;
      app_req_q  <= 1'b0;
      app_len_q  <= 16'd0;
      app_vld_q  <= 1'b0;
      app_din_q  <= 8'd0;
      arp_req_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      tmo_q      <= tmo_d;
      bcnt_q     <= bcnt_d;
      gap_q      <= gap_d;
      last_q     <= last_d;
      gidx_q     <= gidx_d;
      len_q      <= len_d;
      grant_q    <= grant_d;
      data_req_q <= data_req_d;
      done_q     <= done_d;
      err_q      <= err_d;
      link_q     <= link_d;
      app_req_q  <= app_req_d;
      app_len_q  <= app_len_d;
      app_vld_q  <= app_vld_d;
      app_din_q  <= app_din_d;
      arp_req_q  <= arp_req_d;
    end
  end

  assign grant             = grant_q;
  assign data_req          = data_req_q;
  assign done              = done_q;
  assign err               = err_q;
  assign link_ready        = link_q;
  assign app_data_request  = app_req_q;
  assign app_data_length   = app_len_q;
  assign app_data_in_valid = app_vld_q;
  assign app_data_in       = app_din_q;
  assign arp_req           = arp_req_q;

endmodule
